fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Parametrised instruction-fetch stage for the pipeline. It replaces the free-running PC register, +4 adder and combinational instruction memory with a request/response memory port. The block adds branch redirect, halt, decode backpressure and a small in-order prefetch buffer. It sits between the instruction memory and the decode stage, and supplies decode with {instruction, PC, next PC} under a valid/ready handshake.

Parameters:
IWIDTH, 24, instruction width in bits
PWIDTH, 16, PC/address width in bits
PC_STEP, 4, PC increment per sequential fetch
RESET_PC, 0, PC value loaded on reset
BUF_DEPTH, 4, prefetch buffer entries and maximum outstanding requests (power of 2, >=2)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous, active-high reset
halt_i  input  1  suppress new memory requests while high
redirect_i  input  1  branch/jump taken; restart fetch at redirect_pc_i
redirect_pc_i  input  PWIDTH  redirect target
imem_req_o  output  1  memory request valid
imem_addr_o  output  PWIDTH  request address (current fetch PC)
imem_ready_i  input  1  memory accepts request this cycle
imem_rvalid_i  input  1  response valid; in order, latency >=1, cannot be stalled
imem_rdata_i  input  IWIDTH  response instruction
valid_o  output  1  instruction available to decode
ready_i  input  1  decode accepts instruction
instr_o  output  IWIDTH  head instruction
pc_o  output  PWIDTH  PC of instr_o
next_pc_o  output  PWIDTH  pc_o + PC_STEP, mod 2^PWIDTH

Behaviour:
- Reset: fetch_pc=RESET_PC, resp_pc=RESET_PC, buffer empty, outstanding=0, discard=0. Outputs: imem_req_o=0, valid_o=0, instr_o=0, pc_o=RESET_PC, next_pc_o=RESET_PC+PC_STEP. The memory shares rst_i, so no responses from before reset arrive.
- Counters are $clog2(BUF_DEPTH+1) bits wide. The credit condition is outstanding + count < BUF_DEPTH.
- imem_req_o = !rst_i && !halt_i && !redirect_i && credit. imem_addr_o = fetch_pc.
- A request fires when imem_req_o && imem_ready_i. On fire: fetch_pc += PC_STEP (wraps at 2^PWIDTH) and outstanding increments.
- Each imem_rvalid_i decrements outstanding. Same-cycle fire and response leave outstanding unchanged.
- Response handling when discard > 0: the response is dropped and discard decrements.
- Response handling otherwise: {resp_pc, imem_rdata_i} is pushed to the buffer and resp_pc += PC_STEP. The credit rule guarantees the buffer never overflows.
- Output: valid_o = (count != 0). instr_o and pc_o come from the buffer head and are registered. A response reaches valid_o at the earliest one cycle after imem_rvalid_i (no bypass).
- Pop occurs on valid_o && ready_i. instr_o and pc_o must hold stable while valid_o && !ready_i. A push and a pop in the same cycle leave count unchanged.
- Redirect (priority over all other events in the cycle):
  - Buffer is flushed and the same-cycle pop is ignored.
  - fetch_pc and resp_pc load redirect_pc_i.
  - Any imem_rvalid_i in that cycle is dropped.
  - discard = outstanding - imem_rvalid_i, i.e. all still-in-flight stale responses.
  - No request is issued that cycle.
  - A redirect during a non-zero discard recomputes discard the same way.
- Redirect latency, with a 1-cycle memory and imem_ready_i=1:
  - redirect at cycle N;
  - request to the target at N+1;
  - rvalid at N+2;
  - valid_o with pc_o = target at N+3.
- halt_i stops new requests only. In-flight responses still land in the buffer, and decode keeps draining it.
- Simultaneous redirect and halt: the redirect state update happens; no request issues until halt_i drops.
- Reset asserted mid-operation returns the block to the reset state in the next cycle regardless of other inputs.
- Sequential PC wrap: PC_STEP added to 2^PWIDTH-PC_STEP gives 0. next_pc_o wraps the same way.

Test Plan:
- Reset release, 1-cycle memory, ready_i=1 -> imem_addr_o = 0,4,8,... on consecutive cycles. valid_o first high 2 cycles after the first request with pc_o=0, next_pc_o=4. Then one instruction per cycle.
- ready_i=0 for 10 cycles -> exactly 4 (BUF_DEPTH) instructions buffered, imem_req_o=0 while credit is exhausted, instr_o/pc_o held. On ready_i=1, pc_o sequence 0,4,8,12,16 with no loss or duplication.
- 3-cycle memory, 3 requests outstanding (addr 0,4,8), redirect_i with redirect_pc_i=0x0100 -> the 3 stale responses are dropped. The first valid_o shows pc_o=0x0100 with the data for address 0x0100, then 0x0104.
- redirect_i in the same cycle as valid_o&&ready_i and imem_rvalid_i -> pop and response both discarded; next valid_o has pc_o = redirect target.
- halt_i for 5 cycles with 2 requests outstanding -> both responses delivered to decode; no imem_req_o during halt; fetch resumes at the next sequential PC.
- fetch_pc=0xFFFC (PWIDTH=16) -> next request addr 0x0000. Instruction at 0xFFFC shows next_pc_o=0x0000. rst_i asserted mid-stream -> next cycle valid_o=0, imem_addr_o=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: request/response memory port with credit-limited
// in-order prefetch buffer, branch redirect with stale-response discard, and halt.
module fetch_unit #(
  parameter int unsigned IWIDTH    = 24,
  parameter int unsigned PWIDTH    = 16,
  parameter int unsigned PC_STEP   = 4,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              halt_i,
  input  logic              redirect_i,
  input  logic [PWIDTH-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [PWIDTH-1:0] imem_addr_o,
  input  logic              imem_ready_i,
  input  logic              imem_rvalid_i,
  input  logic [IWIDTH-1:0] imem_rdata_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [IWIDTH-1:0] instr_o,
  output logic [PWIDTH-1:0] pc_o,
  output logic [PWIDTH-1:0] next_pc_o
);

  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned AW = $clog2(BUF_DEPTH);
  localparam logic [PWIDTH-1:0] STEP  = PWIDTH'(PC_STEP);
  localparam logic [PWIDTH-1:0] RST_PC = PWIDTH'(RESET_PC);

  logic [PWIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PWIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     discard_q, discard_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     tail_q, tail_d;
  logic [IWIDTH-1:0] buf_instr_q [BUF_DEPTH];
  logic [IWIDTH-1:0] buf_instr_d [BUF_DEPTH];
  logic [PWIDTH-1:0] buf_pc_q [BUF_DEPTH];
  logic [PWIDTH-1:0] buf_pc_d [BUF_DEPTH];

  logic credit, fire, pop, push;

  // Credits cover both buffered entries and in-flight responses, so a
  // response that cannot be stalled always finds a free slot.
  assign credit = ({1'b0, outstanding_q} + {1'b0, count_q}) < (CW + 1)'(BUF_DEPTH);

  always_comb begin
    imem_req_o    = !rst_i && !halt_i && !redirect_i && credit;
    fire          = imem_req_o && imem_ready_i;
    pop           = (count_q != '0) && ready_i;
    push          = 1'b0;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;
    buf_instr_d   = buf_instr_q;
    buf_pc_d      = buf_pc_q;

    if (redirect_i) begin
      fetch_pc_d    = redirect_pc_i;
      resp_pc_d     = redirect_pc_i;
      outstanding_d = outstanding_q - CW'(imem_rvalid_i);
      discard_d     = outstanding_d;
      count_d       = '0;
      head_d        = '0;
      tail_d        = '0;
    end else begin
      if (fire) fetch_pc_d = fetch_pc_q + STEP;
      outstanding_d = outstanding_q + CW'(fire) - CW'(imem_rvalid_i);
      if (imem_rvalid_i) begin
        if (discard_q != '0) discard_d = discard_q - CW'(1);
        else                 push      = 1'b1;
      end
      if (push) begin
        buf_instr_d[tail_q] = imem_rdata_i;
        buf_pc_d[tail_q]    = resp_pc_q;
        tail_d              = tail_q + AW'(1);
        resp_pc_d           = resp_pc_q + STEP;
      end
      if (pop) head_d = head_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q    <= RST_PC;
      resp_pc_q     <= RST_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        buf_instr_q[i] <= '0;
        buf_pc_q[i]    <= RST_PC;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      buf_instr_q   <= buf_instr_d;
      buf_pc_q      <= buf_pc_d;
    end
  end

  assign imem_addr_o = fetch_pc_q;
  assign valid_o     = (count_q != '0);
  assign instr_o     = buf_instr_q[head_q];
  assign pc_o        = buf_pc_q[head_q];
  assign next_pc_o   = pc_o + STEP;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency in-order memory model.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        halt_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [15:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic        imem_ready_i = 1'b1;
  logic        imem_rvalid_i = 1'b0;
  logic [23:0] imem_rdata_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [23:0] instr_o;
  logic [15:0] pc_o;
  logic [15:0] next_pc_o;

  fetch_unit #(
    .IWIDTH(24), .PWIDTH(16), .PC_STEP(4), .RESET_PC(0), .BUF_DEPTH(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .halt_i(halt_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .valid_o(valid_o), .ready_i(ready_i), .instr_o(instr_o), .pc_o(pc_o),
    .next_pc_o(next_pc_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned checks = 0;
  int unsigned failures = 0;

  // Stimulus intent, applied at the next negedge by tick()
  logic        rst_r = 1'b1, halt_r = 1'b0, redir_r = 1'b0, ready_r = 1'b0;
  logic [15:0] rpc_r = '0;
  int unsigned lat = 1;
  int unsigned cyc = 0;
  bit          sch_v [32];
  logic [23:0] sch_d [32];

  function automatic logic [23:0] mem_data(input logic [15:0] a);
    return {8'hC3, a ^ 16'h1234};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    int unsigned slot;
    @(negedge clk_i);
    rst_i         = rst_r;
    halt_i        = halt_r;
    redirect_i    = redir_r;
    redirect_pc_i = rpc_r;
    ready_i       = ready_r;
    imem_ready_i  = 1'b1;
    slot          = cyc % 32;
    if (rst_r) begin
      for (int i = 0; i < 32; i++) sch_v[i] = 1'b0;
      imem_rvalid_i = 1'b0;
    end else begin
      imem_rvalid_i = sch_v[slot];
      imem_rdata_i  = sch_d[slot];
      sch_v[slot]   = 1'b0;
    end
    #1;
    if (imem_req_o && imem_ready_i) begin
      sch_v[(cyc + lat) % 32] = 1'b1;
      sch_d[(cyc + lat) % 32] = mem_data(imem_addr_o);
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_r = 1'b1; halt_r = 1'b0; redir_r = 1'b0;
    tick(); tick();
    rst_r = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [15:0] pc);
    check({tag, "_valid"}, 32'(valid_o), 32'd1);
    check({tag, "_pc"}, 32'(pc_o), 32'(pc));
    check({tag, "_instr"}, 32'(instr_o), 32'(mem_data(pc)));
  endtask

  initial begin
    // Reset state
    lat = 1; ready_r = 1'b1;
    do_reset();
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_instr", 32'(instr_o), 32'd0);
    check("rst_pc", 32'(pc_o), 32'd0);
    check("rst_npc", 32'(next_pc_o), 32'd4);

    // Streaming with a 1-cycle memory
    for (int i = 0; i < 8; i++) begin
      tick();
      check("s_req", 32'(imem_req_o), 32'd1);
      check("s_addr", 32'(imem_addr_o), 32'(4 * i));
      if (i >= 2) begin
        check_head("s", 16'(4 * (i - 2)));
        check("s_npc", 32'(next_pc_o), 32'(4 * (i - 1)));
      end else begin
        check("s_valid0", 32'(valid_o), 32'd0);
      end
    end

    // Decode backpressure fills the buffer, then drains in order
    ready_r = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_req", 32'(imem_req_o), 32'(i < 4));
      if (i < 4) check("bp_addr", 32'(imem_addr_o), 32'(4 * i));
      if (i >= 2) check_head("bp_hold", 16'h0000);
      else check("bp_valid0", 32'(valid_o), 32'd0);
    end
    ready_r = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      if (j == 0) check("bp_full_req", 32'(imem_req_o), 32'd0);
      check_head("bp_drain", 16'(4 * j));
    end

    // Redirect with three stale responses in flight
    lat = 3;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rd_addr", 32'(imem_addr_o), 32'(4 * i));
    end
    redir_r = 1'b1; rpc_r = 16'h0100;
    tick();
    check("rd_req_n", 32'(imem_req_o), 32'd0);
    redir_r = 1'b0;
    tick();
    check("rd_addr_t", 32'(imem_addr_o), 32'h0100);
    check("rd_req_t", 32'(imem_req_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rd_stale", 32'(valid_o), 32'd0);
    end
    tick();
    check_head("rd_t0", 16'h0100);
    tick();
    check_head("rd_t1", 16'h0104);

    // Redirect colliding with pop and response
    lat = 1;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    redir_r = 1'b1; rpc_r = 16'h0200;
    tick();
    check_head("rc_pop", 16'h0008);
    check("rc_rvalid", 32'(imem_rvalid_i), 32'd1);
    check("rc_req", 32'(imem_req_o), 32'd0);
    redir_r = 1'b0;
    tick();
    check("rc_v1", 32'(valid_o), 32'd0);
    check("rc_addr", 32'(imem_addr_o), 32'h0200);
    tick();
    check("rc_v2", 32'(valid_o), 32'd0);
    tick();
    check_head("rc_t", 16'h0200);
    check("rc_npc", 32'(next_pc_o), 32'h0204);

    // Halt with two requests outstanding
    lat = 2;
    do_reset();
    tick(); tick();
    halt_r = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("h_req", 32'(imem_req_o), 32'd0);
      if (i == 1) check_head("h_d0", 16'h0000);
      else if (i == 2) check_head("h_d1", 16'h0004);
      else check("h_idle", 32'(valid_o), 32'd0);
    end
    halt_r = 1'b0;
    tick();
    check("h_resume_req", 32'(imem_req_o), 32'd1);
    check("h_resume_addr", 32'(imem_addr_o), 32'h0008);

    // PC wrap, then reset mid-stream
    lat = 1;
    do_reset();
    tick();
    redir_r = 1'b1; rpc_r = 16'hFFF8;
    tick();
    redir_r = 1'b0;
    tick();
    check("w_a0", 32'(imem_addr_o), 32'hFFF8);
    tick();
    check("w_a1", 32'(imem_addr_o), 32'hFFFC);
    tick();
    check("w_a2", 32'(imem_addr_o), 32'h0000);
    check_head("w_h0", 16'hFFF8);
    tick();
    check_head("w_h1", 16'hFFFC);
    check("w_npc", 32'(next_pc_o), 32'h0000);
    tick();
    check_head("w_h2", 16'h0000);
    rst_r = 1'b1;
    tick();
    check("mr_req", 32'(imem_req_o), 32'd0);
    rst_r = 1'b0;
    tick();
    check("mr_valid", 32'(valid_o), 32'd0);
    check("mr_addr", 32'(imem_addr_o), 32'h0000);
    check("mr_req1", 32'(imem_req_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
